// File: rtl/note_synth_if.sv
// Bus bundle for note_synth: note grid input, play control and the
// valid/ready audio sample output with its status flags.
`timescale 1ns/1ps
interface note_synth_if;
   logic [31:0]        note_in;
   logic               note_strobe;
   logic               play_en;
   logic               sample_ready;
   logic signed [23:0] sample_out;
   logic               sample_valid;
   logic [2:0]         active_voices;
   logic               overrun;

   modport master (
      output note_in, note_strobe, play_en, sample_ready,
      input  sample_out, sample_valid, active_voices, overrun
   );

   modport slave (
      input  note_in, note_strobe, play_en, sample_ready,
      output sample_out, sample_valid, active_voices, overrun
   );
endinterface

// File: rtl/note_synth.sv
// note_synth: six square-wave voices (one per guitar string) mixed into a
// 24-bit signed sample once per audio tick.
// Optional envelope decay is enabled by defining NOTE_SYNTH_DECAY_EN.
//
// state   | meaning
// IDLE    | waiting for the next sample tick
// ACCUM   | summing voices 0..5, one per cycle
// PRESENT | loading the finished sum into sample_out
`timescale 1ns/1ps
module note_synth #(
   parameter int SAMPLE_DIV = 1042,
   parameter int AMP_SHIFT  = 11
) (
   input logic         clk,
   input logic         resetn,
   note_synth_if.slave bus
);
   localparam int            CW     = $clog2(SAMPLE_DIV);
   localparam logic [CW-1:0] RELOAD = CW'(SAMPLE_DIV - 1);

   // Phase increments per 48 kHz sample, index = string*5 + fret.
   localparam logic [9:0] INC_TAB [30] = '{
      10'd113, 10'd119, 10'd126, 10'd134, 10'd142,
      10'd150, 10'd159, 10'd169, 10'd179, 10'd189,
      10'd200, 10'd212, 10'd225, 10'd238, 10'd253,
      10'd268, 10'd284, 10'd300, 10'd318, 10'd337,
      10'd337, 10'd357, 10'd378, 10'd401, 10'd425,
      10'd450, 10'd477, 10'd505, 10'd535, 10'd567
   };

   typedef enum logic [1:0] {IDLE, ACCUM, PRESENT} state_t;
   state_t state, state_nxt;

   logic [CW-1:0]      cnt;
   logic               tick;
   logic [29:0]        shadow;
   logic               pend;
   logic               apply;
   logic [15:0]        phase [6];
   logic [9:0]         inc [6];
   logic [7:0]         env [6];
   logic [5:0]         act;
   logic [5:0]         new_act;
   logic [9:0]         new_inc [6];
   logic [2:0]         new_cnt;
   logic [2:0]         vidx;
   logic signed [23:0] acc;
   logic signed [23:0] term;
   logic               accum_en;
   logic               present_en;

   assign tick  = (cnt == '0);
   assign apply = tick & pend;

   // Sample-rate down-counter; tick on terminal count, then reload.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   cnt <= RELOAD;
      else if (tick) cnt <= RELOAD;
      else           cnt <= cnt - CW'(1);
   end

   // Shadow latch; a pending note is consumed by the next tick, so a strobe
   // landing on a tick waits for the following one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shadow <= '0;
         pend   <= 1'b0;
      end else if (bus.note_strobe) begin
         shadow <= bus.note_in[29:0];
         pend   <= 1'b1;
      end else if (tick) begin
         pend   <= 1'b0;
      end
   end

   // Decode the shadow grid: highest set fret per string wins.
   always_comb begin
      new_cnt = '0;
      for (int s = 0; s < 6; s++) begin
         new_act[s] = 1'b0;
         new_inc[s] = '0;
         for (int f = 0; f < 5; f++) begin
            if (shadow[5'(6*f + s)]) begin
               new_act[s] = 1'b1;
               new_inc[s] = INC_TAB[5'(s*5 + f)];
            end
         end
         new_cnt = new_cnt + 3'(new_act[s]);
      end
   end

`ifdef NOTE_SYNTH_DECAY_EN
   logic [7:0] decay_cnt;
   logic       decay_step;
   assign decay_step = tick & (decay_cnt == 8'hFF);

   // Counts ticks since the last apply; every 256th tick steps envelopes down.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    decay_cnt <= '0;
      else if (apply) decay_cnt <= '0;
      else if (tick)  decay_cnt <= decay_cnt + 8'd1;
   end
`endif

   // Voice state: restart on apply, otherwise advance the voice being summed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int s = 0; s < 6; s++) begin
            phase[s] <= '0;
            inc[s]   <= '0;
            env[s]   <= '0;
         end
         act               <= '0;
         bus.active_voices <= '0;
      end else if (apply) begin
         for (int s = 0; s < 6; s++) begin
            phase[s] <= '0;
            inc[s]   <= new_inc[s];
            env[s]   <= new_act[s] ? 8'd255 : 8'd0;
         end
         act               <= new_act;
         bus.active_voices <= new_cnt;
      end else begin
         if (accum_en) phase[vidx] <= phase[vidx] + 16'(inc[vidx]);
`ifdef NOTE_SYNTH_DECAY_EN
         if (decay_step) begin
            for (int s = 0; s < 6; s++)
               if (env[s] != 8'd0) env[s] <= env[s] - 8'd1;
         end
`endif
      end
   end

   // Square-wave term of the current voice, from its pre-increment phase.
   always_comb begin
      term = '0;
      if (bus.play_en && act[vidx]) begin
         term = $signed({16'd0, env[vidx]}) <<< AMP_SHIFT;
         if (phase[vidx][15]) term = -term;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // FSM next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (tick) state_nxt = ACCUM;
         ACCUM:   if (vidx == 3'd5) state_nxt = PRESENT;
         PRESENT: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      accum_en   = (state == ACCUM);
      present_en = (state == PRESENT);
   end

   // Accumulator; cleared whenever idle so a reset or new tick starts fresh.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc  <= '0;
         vidx <= '0;
      end else if (accum_en) begin
         acc  <= acc + term;
         vidx <= vidx + 3'd1;
      end else if (!present_en) begin
         acc  <= '0;
         vidx <= '0;
      end
   end

   // Output register with valid/ready handshake and sticky overrun.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bus.sample_out   <= '0;
         bus.sample_valid <= 1'b0;
         bus.overrun      <= 1'b0;
      end else if (present_en) begin
         bus.sample_out   <= acc;
         bus.sample_valid <= 1'b1;
         if (bus.sample_valid && !bus.sample_ready) bus.overrun <= 1'b1;
      end else if (bus.sample_valid && bus.sample_ready) begin
         bus.sample_valid <= 1'b0;
      end
   end
endmodule
